ok_register_bank: RTL and testbench
===================================

Name: ok_register_bank

Overview:
- Register file that consumes the Register Bridge endpoint bus: ep_address, ep_write, ep_dataout and ep_read. It returns read data on ep_datain.
- Provides three kinds of register:
  - writable control registers, with per-register write strobes;
  - a live status word;
  - a sticky event register (write-1-to-clear) with a mask and an interrupt output.
- Occupies a 64-word window, so several banks can share one bridge. Their ep_datain outputs are OR-combined.

Parameters:
- BASE_ADDR, 32'h0000_0000: window base; bits [5:0] must be 0.
- NUM_CTRL, 8: number of control registers, range 1..32.
- ID_VALUE, 32'h0B1D_0001: constant returned at offset 0x23.

Ports:
- okClk  in  1  sole clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- ep_address  in  32  register address from the bridge.
- ep_write  in  1  one-cycle write strobe.
- ep_dataout  in  32  write data from the bridge.
- ep_read  in  1  one-cycle read strobe.
- ep_datain  out  32  registered read data to the bridge.
- ctrl_regs  out  32*NUM_CTRL  control registers, flattened; register k occupies bits [32k+31:32k].
- ctrl_wr_stb  out  NUM_CTRL  bit k pulses for one cycle after register k is written.
- status_in  in  32  live status word, sampled at read time.
- event_in  in  32  event bits; any cycle with a bit high sets the corresponding sticky bit.
- irq  out  1  registered OR of (sticky & mask).

Behaviour:
- Clock and reset: one clock, okClk. Reset is synchronous, active-high.
- Hit decode: hit = (ep_address[31:6] == BASE_ADDR[31:6]). off = ep_address[5:0].
- Address map (word offsets):
  - 0x00..NUM_CTRL-1: ctrl[k], read/write.
  - 0x20: status_in, read-only.
  - 0x21: sticky events, write-1-to-clear.
  - 0x22: event mask, read/write.
  - 0x23: ID_VALUE, read-only.
  - Any other offset is unmapped.
- Write (ep_write && hit):
  - ctrl[off] or mask takes ep_dataout at the clock edge.
  - ctrl_wr_stb[off] is 1 in the following cycle only.
  - A write to offset 0x21 clears every sticky bit where ep_dataout is 1.
  - Writes to read-only or unmapped offsets are ignored and produce no strobe.
  - Writes that miss the window are ignored.
- Read (ep_read): ep_datain is registered and updates at the edge where ep_read is sampled, giving one-cycle latency.
  - Hit on a mapped offset: the value as it was before that edge.
  - Hit on an unmapped offset: 32'h0.
  - Miss: 32'h0, so OR-combining with other banks is safe.
  - Without ep_read, ep_datain holds its value.
- Simultaneous read and write to the same offset: both are performed; the read returns the old value.
- Sticky events: next = (sticky & ~clr) | event_in, where clr is the write-1-to-clear mask for this cycle (0 when there is no 0x21 write). Set wins over a simultaneous clear.
- Status at 0x20: status_in is sampled combinationally at the read edge; there is no synchroniser, so the source must be synchronous to okClk.
- irq: irq <= |(sticky_next & mask_next). It therefore asserts one cycle after the event edge, and deasserts one cycle after the clear or mask write.
- Reset values, applied at the first reset edge and held while reset is high:
  - ctrl_regs = 0, ctrl_wr_stb = 0, sticky = 0, mask = 0, ep_datain = 0, irq = 0.
  - Reads, writes and events presented in reset cycles are discarded.
- Offsets 0x00..0x1F at or above NUM_CTRL behave as unmapped.
- Addresses are not wrapped; only the upper-bit compare decides a hit.

Test Plan:
- Reset, then write 0xA5A5_0001 to BASE+0x03 -> ctrl_regs[127:96] = 0xA5A5_0001 one edge later. ctrl_wr_stb = 8'b0000_1000 for exactly one cycle. A read of BASE+0x03 returns 0xA5A5_0001 on ep_datain one cycle after the read strobe.
- Read BASE+0x23 -> ep_datain = 0x0B1D_0001. Then read BASE+0x40 (miss) -> ep_datain = 0. Then read BASE+0x15 (unmapped) -> 0. Then write to 0x23 -> no strobe, and the ID is unchanged.
- Apply one-cycle pulse event_in = 0x0000_0011 with mask = 0 -> 0x21 reads 0x11 and irq stays 0. Write mask = 0x10 -> irq = 1 one cycle later. Write 0x10 to 0x21 -> sticky = 0x01 and irq falls one cycle later.
- Hold event_in[4] high during a write-1-to-clear of 0x10 -> bit 4 remains set (set wins).
- Same-cycle read and write of BASE+0x00 (old 0x1, new 0x2) -> ep_datain = 0x1, then ctrl[0] = 0x2.
- Write 0xFFFF_FFFF to ctrl[1] and mask, then assert reset for one cycle during a concurrent read strobe -> all outputs are 0 after the edge, and ep_datain = 0.

Source files
------------

// File: rtl/ok_register_bank.sv
// Register bank on the Register Bridge endpoint bus: control registers with write strobes,
// a live status word, a write-1-to-clear sticky event register with mask, and an ID word.
module ok_register_bank #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          NUM_CTRL  = 8,
    parameter logic [31:0] ID_VALUE  = 32'h0B1D_0001
) (
    input  logic                     okClk,
    input  logic                     reset,
    input  logic [31:0]              ep_address,
    input  logic                     ep_write,
    input  logic [31:0]              ep_dataout,
    input  logic                     ep_read,
    output logic [31:0]              ep_datain,
    output logic [32*NUM_CTRL-1:0]   ctrl_regs,
    output logic [NUM_CTRL-1:0]      ctrl_wr_stb,
    input  logic [31:0]              status_in,
    input  logic [31:0]              event_in,
    output logic                     irq
);

    localparam logic [5:0] OFF_STATUS = 6'h20;
    localparam logic [5:0] OFF_STICKY = 6'h21;
    localparam logic [5:0] OFF_MASK   = 6'h22;
    localparam logic [5:0] OFF_ID     = 6'h23;

    logic [31:0]         ctrl_q [NUM_CTRL];
    logic [31:0]         sticky_q;
    logic [31:0]         mask_q;
    logic                hit;
    logic                wr_hit;
    logic [5:0]          off;
    logic [NUM_CTRL-1:0] stb_next;
    logic [31:0]         clr;
    logic [31:0]         sticky_next;
    logic [31:0]         mask_next;
    logic [31:0]         rd_data;

    assign hit    = (ep_address[31:6] == BASE_ADDR[31:6]);
    assign off    = ep_address[5:0];
    assign wr_hit = ep_write && hit;

    for (genvar g = 0; g < NUM_CTRL; g++) begin : g_flat
        assign ctrl_regs[32*g +: 32] = ctrl_q[g];
    end

    always_comb begin
        stb_next = '0;
        for (int k = 0; k < NUM_CTRL; k++) begin
            if (wr_hit && off == 6'(k)) begin
                stb_next[k] = 1'b1;
            end
        end
    end

    // Set wins over clear: event_in is OR-ed in after the write-1-to-clear mask.
    assign clr         = (wr_hit && off == OFF_STICKY) ? ep_dataout : 32'h0;
    assign sticky_next = (sticky_q & ~clr) | event_in;
    assign mask_next   = (wr_hit && off == OFF_MASK) ? ep_dataout : mask_q;

    // Read mux returns pre-edge values; misses and unmapped offsets give 0 for OR-combining.
    always_comb begin
        rd_data = 32'h0;
        if (hit) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (off == 6'(k)) begin
                    rd_data = ctrl_q[k];
                end
            end
            case (off)
                OFF_STATUS: rd_data = status_in;
                OFF_STICKY: rd_data = sticky_q;
                OFF_MASK:   rd_data = mask_q;
                OFF_ID:     rd_data = ID_VALUE;
                default:    ;
            endcase
        end
    end

    always_ff @(posedge okClk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                ctrl_q[k] <= 32'h0;
            end
            ctrl_wr_stb <= '0;
            sticky_q    <= 32'h0;
            mask_q      <= 32'h0;
            ep_datain   <= 32'h0;
            irq         <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_CTRL; k++) begin
                if (stb_next[k]) begin
                    ctrl_q[k] <= ep_dataout;
                end
            end
            ctrl_wr_stb <= stb_next;
            sticky_q    <= sticky_next;
            mask_q      <= mask_next;
            irq         <= |(sticky_next & mask_next);
            if (ep_read) begin
                ep_datain <= rd_data;
            end
        end
    end

endmodule

// File: tb/tb_ok_register_bank.sv
// Self-checking bench for ok_register_bank: read results are queued when a read is driven
// and compared by a monitor one edge later; other outputs are checked directly.
module tb_ok_register_bank;

    logic         okClk = 1'b0;
    logic         reset;
    logic [31:0]  ep_address;
    logic         ep_write;
    logic [31:0]  ep_dataout;
    logic         ep_read;
    logic [31:0]  ep_datain;
    logic [255:0] ctrl_regs;
    logic [7:0]   ctrl_wr_stb;
    logic [31:0]  status_in;
    logic [31:0]  event_in;
    logic         irq;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    ok_register_bank #(
        .BASE_ADDR(32'h0000_0000),
        .NUM_CTRL (8),
        .ID_VALUE (32'h0B1D_0001)
    ) dut (
        .okClk      (okClk),
        .reset      (reset),
        .ep_address (ep_address),
        .ep_write   (ep_write),
        .ep_dataout (ep_dataout),
        .ep_read    (ep_read),
        .ep_datain  (ep_datain),
        .ctrl_regs  (ctrl_regs),
        .ctrl_wr_stb(ctrl_wr_stb),
        .status_in  (status_in),
        .event_in   (event_in),
        .irq        (irq)
    );

    always #5 okClk = ~okClk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    // Inputs change only on the falling edge; the call returns on the next falling edge.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [31:0] addr,
                                 input logic [31:0] data, input logic [31:0] ev,
                                 input logic [31:0] exp_rd);
        ep_write   = wr;
        ep_read    = rd;
        ep_address = addr;
        ep_dataout = data;
        event_in   = ev;
        if (rd) exp_q.push_back(exp_rd);
        @(negedge okClk);
        ep_write   = 1'b0;
        ep_read    = 1'b0;
        ep_address = 32'h0;
        ep_dataout = 32'h0;
        event_in   = 32'h0;
    endtask

    always @(posedge okClk) begin
        if (ep_read && !reset) begin
            #1;
            if (exp_q.size() == 0) checkOutput("rd_queue_empty", ep_datain, 32'hxxxx_xxxx);
            else checkOutput("rd_data", ep_datain, exp_q.pop_front());
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset = 1'b1; ep_address = 0; ep_write = 0; ep_dataout = 0; ep_read = 0;
        status_in = 0; event_in = 0;
        @(negedge okClk);
        @(negedge okClk);
        checkOutput("rst_ctrl", {31'h0, |ctrl_regs}, 32'h0);
        checkOutput("rst_stb", {24'h0, ctrl_wr_stb}, 32'h0);
        checkOutput("rst_irq", {31'h0, irq}, 32'h0);
        checkOutput("rst_datain", ep_datain, 32'h0);
        reset = 1'b0;
        @(negedge okClk);

        applyStimulus(1, 0, 32'h03, 32'hA5A5_0001, 0, 0);
        checkOutput("ctrl3", ctrl_regs[127:96], 32'hA5A5_0001);
        checkOutput("stb3", {24'h0, ctrl_wr_stb}, 32'h08);
        applyStimulus(0, 0, 0, 0, 0, 0);
        checkOutput("stb3_off", {24'h0, ctrl_wr_stb}, 32'h0);
        applyStimulus(0, 1, 32'h03, 0, 0, 32'hA5A5_0001);

        applyStimulus(0, 1, 32'h23, 0, 0, 32'h0B1D_0001);
        applyStimulus(0, 1, 32'h40, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h15, 0, 0, 32'h0);
        applyStimulus(1, 0, 32'h23, 32'hDEAD_BEEF, 0, 0);
        checkOutput("stb_id_wr", {24'h0, ctrl_wr_stb}, 32'h0);
        applyStimulus(0, 1, 32'h23, 0, 0, 32'h0B1D_0001);

        applyStimulus(0, 0, 0, 0, 32'h11, 0);
        checkOutput("irq_masked", {31'h0, irq}, 32'h0);
        applyStimulus(0, 1, 32'h21, 0, 0, 32'h11);
        checkOutput("irq_masked2", {31'h0, irq}, 32'h0);
        applyStimulus(1, 0, 32'h22, 32'h10, 0, 0);
        checkOutput("irq_on", {31'h0, irq}, 32'h1);
        applyStimulus(0, 1, 32'h22, 0, 0, 32'h10);
        applyStimulus(1, 0, 32'h21, 32'h10, 0, 0);
        checkOutput("irq_clr", {31'h0, irq}, 32'h0);
        applyStimulus(0, 1, 32'h21, 0, 0, 32'h01);

        applyStimulus(1, 0, 32'h21, 32'h10, 32'h10, 0);
        checkOutput("irq_setwins", {31'h0, irq}, 32'h1);
        applyStimulus(0, 1, 32'h21, 0, 0, 32'h11);
        applyStimulus(1, 0, 32'h21, 32'hFFFF_FFFF, 0, 0);
        checkOutput("irq_clr_all", {31'h0, irq}, 32'h0);
        applyStimulus(0, 1, 32'h21, 0, 0, 32'h0);

        applyStimulus(1, 0, 32'h00, 32'h1, 0, 0);
        checkOutput("stb0", {24'h0, ctrl_wr_stb}, 32'h01);
        applyStimulus(1, 1, 32'h00, 32'h2, 0, 32'h1);
        checkOutput("ctrl0_new", ctrl_regs[31:0], 32'h2);
        checkOutput("stb0_again", {24'h0, ctrl_wr_stb}, 32'h01);

        applyStimulus(1, 0, 32'h08, 32'h55, 0, 0);
        checkOutput("stb_unmapped", {24'h0, ctrl_wr_stb}, 32'h0);
        applyStimulus(0, 1, 32'h08, 0, 0, 32'h0);
        applyStimulus(1, 0, 32'h40, 32'h77, 0, 0);
        checkOutput("miss_ctrl0", ctrl_regs[31:0], 32'h2);
        checkOutput("miss_stb", {24'h0, ctrl_wr_stb}, 32'h0);

        status_in = 32'h1234_5678;
        applyStimulus(0, 1, 32'h20, 0, 0, 32'h1234_5678);
        status_in = 32'h0;

        applyStimulus(1, 0, 32'h01, 32'hFFFF_FFFF, 0, 0);
        checkOutput("ctrl1", ctrl_regs[63:32], 32'hFFFF_FFFF);
        applyStimulus(1, 0, 32'h22, 32'hFFFF_FFFF, 32'h1, 0);
        checkOutput("irq_pre_rst", {31'h0, irq}, 32'h1);
        applyStimulus(0, 1, 32'h01, 0, 0, 32'hFFFF_FFFF);

        reset = 1'b1; ep_read = 1'b1; ep_address = 32'h01; event_in = 32'h4;
        @(negedge okClk);
        reset = 1'b0; ep_read = 1'b0; ep_address = 0; event_in = 0;
        checkOutput("rst2_ctrl", {31'h0, |ctrl_regs}, 32'h0);
        checkOutput("rst2_stb", {24'h0, ctrl_wr_stb}, 32'h0);
        checkOutput("rst2_irq", {31'h0, irq}, 32'h0);
        checkOutput("rst2_datain", ep_datain, 32'h0);
        applyStimulus(0, 1, 32'h22, 0, 0, 32'h0);
        applyStimulus(0, 1, 32'h21, 0, 0, 32'h0);

        @(negedge okClk);
        checkOutput("rd_queue_drained", exp_q.size(), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
